// File: rtl/ntt_bram_pkg.sv
// Shared definitions for the NTT coefficient-buffer responder.
// Contents: default geometry constants, the owner/phase state enum, and helpers that
// turn an engine byte address into a word index and flag illegal engine accesses.
package ntt_bram_pkg;

    localparam int unsigned DEPTH      = 64;
    localparam int unsigned DW         = 64;
    localparam int unsigned AW         = 10;
    localparam int unsigned WORD_SHIFT = 2;

    // LOAD and UNLOAD: host owns the array. RUN: the engine owns it.
    typedef enum logic [1:0] {
        LOAD,
        RUN,
        UNLOAD
    } state_e;

    function automatic logic [AW-1:0] word_idx(input logic [AW-1:0] addr);
        return addr >> WORD_SHIFT;
    endfunction

    // Legal engine access: word aligned and inside the buffer.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        return (addr[WORD_SHIFT-1:0] == '0) && (word_idx(addr) < AW'(DEPTH));
    endfunction

endpackage

// File: rtl/ntt_bram_skid.sv
// Two-entry valid/ready output buffer for the unload stream.
// The head entry drives the output directly, so out_data_o/out_valid_o come straight from
// flops and stay stable while stalled. in_ready_o depends only on internal state, so there
// is no combinational path from out_ready_i back to the producer.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush_i        drop both entries (synchronous)
//   in_valid_i/in_ready_o/in_data_i     producer side
//   out_valid_o/out_ready_i/out_data_o  consumer side
module ntt_bram_skid #(
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic          head_vld_q, head_vld_d;
    logic          tail_vld_q, tail_vld_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          push, pop;

    assign in_ready_o  = !tail_vld_q;
    assign out_valid_o = head_vld_q;
    assign out_data_o  = head_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = head_vld_q && out_ready_i;

    always_comb begin
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        head_d     = head_q;
        tail_d     = tail_q;
        if (flush_i) begin
            head_vld_d = 1'b0;
            tail_vld_d = 1'b0;
        end else begin
            if (pop) begin
                head_d     = tail_q;
                head_vld_d = tail_vld_q;
                tail_vld_d = 1'b0;
            end
            // A push lands in the head if it is (or has just become) empty.
            if (push) begin
                if (!head_vld_d) begin
                    head_d     = in_data_i;
                    head_vld_d = 1'b1;
                end else begin
                    tail_d     = in_data_i;
                    tail_vld_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: rtl/ntt_bram_responder.sv
// Memory-side responder for the NTT wrapper's 64-bit BRAM master port.
// Holds the coefficient buffer: a host loads it over a valid/ready stream, the engine is
// then released from reset and served byte-addressed reads/writes, and once the engine
// reports completion the results are drained over a valid/ready stream.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   BRAM_addr_0/din_0/dout_0/en_0/we_0  engine BRAM port (word index = addr[AW-1:2])
//   ntt_done_i                      engine completion level
//   engine_rst                      synchronous active-high engine reset (low only in RUN)
//   s_valid/s_ready/s_data          load stream, word 0 first
//   m_valid/m_ready/m_data          unload stream, word 0 first
//   busy                            high in RUN and UNLOAD
//   addr_err                        sticky illegal engine access flag
// READ_LAT must be 1..3; the engine waits three cycles for read data.
module ntt_bram_responder #(
    parameter int unsigned DEPTH    = ntt_bram_pkg::DEPTH,
    parameter int unsigned DW       = ntt_bram_pkg::DW,
    parameter int unsigned AW       = ntt_bram_pkg::AW,
    parameter int unsigned READ_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] BRAM_addr_0,
    input  logic [DW-1:0] BRAM_din_0,
    output logic [DW-1:0] BRAM_dout_0,
    input  logic          BRAM_en_0,
    input  logic          BRAM_we_0,
    input  logic          ntt_done_i,
    output logic          engine_rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          busy,
    output logic          addr_err
);

    import ntt_bram_pkg::*;

    localparam int unsigned IW = $clog2(DEPTH);
    typedef logic [IW-1:0] idx_t;
    typedef logic [IW:0]   ptr_t;
    localparam idx_t LAST_IDX = idx_t'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    state_e        state_q, state_d;
    idx_t          cnt_q, cnt_d;
    ptr_t          rd_ptr_q, rd_ptr_d;
    logic          done_q, done_d;
    logic          engine_rst_q, engine_rst_d;
    logic          s_ready_q, s_ready_d;
    logic          addr_err_q, addr_err_d;
    logic [DW-1:0] rd_pipe_q [READ_LAT];
    logic [DW-1:0] rd_pipe_d [READ_LAT];

    logic          mem_we;
    idx_t          mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          eng_ok, done_rise;
    idx_t          eng_idx;
    logic          skid_in_valid, skid_in_ready, skid_flush;

    assign eng_ok     = addr_ok(BRAM_addr_0);
    assign eng_idx    = idx_t'(word_idx(BRAM_addr_0));
    assign done_rise  = ntt_done_i && !done_q;
    // Combinational read sampled by flops at the same edge as the write: read-first.
    assign mem_rdata  = mem[mem_raddr];
    assign skid_flush = (state_q != UNLOAD);

    assign engine_rst  = engine_rst_q;
    assign s_ready     = s_ready_q;
    assign busy        = (state_q != LOAD);
    assign addr_err    = addr_err_q;
    assign BRAM_dout_0 = rd_pipe_q[READ_LAT-1];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_ptr_d      = rd_ptr_q;
        addr_err_d    = addr_err_q;
        done_d        = ntt_done_i;
        mem_we        = 1'b0;
        mem_waddr     = '0;
        mem_wdata     = '0;
        mem_raddr     = '0;
        skid_in_valid = 1'b0;

        case (state_q)
            LOAD: begin
                rd_ptr_d = '0;
                if (s_valid && s_ready_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = cnt_q;
                    mem_wdata = s_data;
                    if (cnt_q == LAST_IDX) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + idx_t'(1);
                    end
                end
            end
            RUN: begin
                rd_ptr_d  = '0;
                mem_raddr = eng_idx;
                if (BRAM_en_0 && BRAM_we_0 && eng_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = eng_idx;
                    mem_wdata = BRAM_din_0;
                end
                if (BRAM_en_0 && !eng_ok) begin
                    addr_err_d = 1'b1;
                end
                if (done_rise) begin
                    state_d = UNLOAD;
                    cnt_d   = '0;
                end
            end
            UNLOAD: begin
                // rd_ptr_q prefetches into the skid buffer; cnt_q counts delivered beats.
                mem_raddr     = rd_ptr_q[IW-1:0];
                skid_in_valid = !rd_ptr_q[IW];
                if (skid_in_valid && skid_in_ready) begin
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                end
                if (m_valid && m_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + idx_t'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase

        engine_rst_d = (state_d != RUN);
        s_ready_d    = (state_d == LOAD);

        // Stage 0 holds while the engine port is idle; outside RUN the pipe drains to zero.
        rd_pipe_d[0] = rd_pipe_q[0];
        if (state_q != RUN) begin
            rd_pipe_d[0] = '0;
        end else if (BRAM_en_0) begin
            rd_pipe_d[0] = eng_ok ? mem_rdata : '0;
        end
        for (int i = 1; i < int'(READ_LAT); i++) begin
            rd_pipe_d[i] = rd_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            done_q       <= 1'b1;  // a level already high at reset release is not an edge
            engine_rst_q <= 1'b1;
            s_ready_q    <= 1'b0;
            addr_err_q   <= 1'b0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                rd_pipe_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            done_q       <= done_d;
            engine_rst_q <= engine_rst_d;
            s_ready_q    <= s_ready_d;
            addr_err_q   <= addr_err_d;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                rd_pipe_q[i] <= rd_pipe_d[i];
            end
        end
    end

    // Coefficient storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    ntt_bram_skid #(
        .DW(DW)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (skid_flush),
        .in_valid_i (skid_in_valid),
        .in_ready_o (skid_in_ready),
        .in_data_i  (mem_rdata),
        .out_valid_o(m_valid),
        .out_ready_i(m_ready),
        .out_data_o (m_data)
    );

endmodule

// File: doc/ntt_bram_responder.md
Name: ntt_bram_responder

Overview:
- Memory-side responder for the NTT engine wrapper's 64-bit BRAM master port.
- Holds the 64-word coefficient buffer. A host fills it over a valid/ready load stream. The block then releases the engine from reset and serves the engine's byte-addressed reads and writes.
- After the engine signals completion, the block drains the 64 result words over a valid/ready unload stream and rearms for the next transform.
- Sits between the host/DMA fabric and the NTT wrapper; replaces the Xilinx BRAM IP in simulation and in ASIC-style builds.

Parameters:
- DEPTH, 64, number of 64-bit words; power of two.
- DW, 64, data width in bits.
- AW, 10, engine-side byte address width.
- READ_LAT, 2, engine-side read latency in cycles, from address sample to valid dout; legal values 1..3.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- BRAM_addr_0  in  AW  engine byte address; word index = addr[AW-1:2].
- BRAM_din_0  in  DW  engine write data.
- BRAM_dout_0  out  DW  engine read data.
- BRAM_en_0  in  1  engine port enable.
- BRAM_we_0  in  1  engine write enable.
- ntt_done_i  in  1  engine completion level.
- engine_rst  out  1  synchronous active-high reset to the engine.
- s_valid  in  1  load stream valid.
- s_ready  out  1  load stream ready.
- s_data  in  DW  load stream data; word 0 first.
- m_valid  out  1  unload stream valid.
- m_ready  in  1  unload stream ready.
- m_data  out  DW  unload stream data; word 0 first.
- busy  out  1  high in RUN and UNLOAD.
- addr_err  out  1  sticky: engine accessed a word index >= DEPTH or a non-zero addr[1:0] while in RUN.

Behaviour:
- Reset values: state=LOAD, cnt=0, engine_rst=1, s_ready=0 (first cycle after reset release; 1 thereafter in LOAD), m_valid=0, m_data=0, BRAM_dout_0=0, busy=0, addr_err=0. Memory contents are not reset.
- Single array with one read port and one write port. Ownership by state: host in LOAD/UNLOAD, engine in RUN. No arbitration is needed.

State LOAD:
- s_ready=1.
- Each s_valid&&s_ready writes mem[cnt] and increments cnt.
- The handshake at cnt==DEPTH-1 moves to RUN with cnt=0.
- Engine port is ignored: writes dropped, BRAM_dout_0 holds 0.

State RUN:
- engine_rst=0 from the first RUN cycle.
- Read: when BRAM_en_0 is high, mem[addr[7:2]] appears on BRAM_dout_0 exactly READ_LAT cycles after the address is sampled, through a READ_LAT-stage register pipeline. The engine waits 3 cycles, so READ_LAT must be <= 3.
- Write: BRAM_en_0&&BRAM_we_0 writes BRAM_din_0 to the word in the same cycle. The engine holds we high for several cycles per address; repeated writes are idempotent.
- Read-during-write to the same word returns old data (read-first).
- Out-of-range word index or non-zero addr[1:0]: write dropped, read returns 0, addr_err set (sticky until rst_n).
- Rising edge of ntt_done_i (registered edge detect) moves to UNLOAD. Writes in the transition cycle still commit.

State UNLOAD:
- engine_rst=1 from entry, which clears the engine's done flag; ntt_done_i is ignored from then on.
- The host read pointer prefetches into a 2-entry output buffer.
- m_valid rises 1 cycle after entry with m_data=mem[0].
- Throughput is 1 word/cycle while m_ready is held high; no bubbles.
- m_data/m_valid stay stable while m_valid&&!m_ready (AXI-stream rules).
- The handshake of word DEPTH-1 moves to LOAD with cnt=0 and m_valid=0 the next cycle.

Boundaries:
- s_valid in RUN/UNLOAD is not accepted (s_ready=0).
- ntt_done_i high on the RUN entry cycle counts as an edge only if it was low the previous cycle. A stale level from before reset is ignored.
- rst_n asserted mid-operation aborts immediately to LOAD. Output buffer is flushed, pipelines cleared, engine_rst=1.

Decomposition:
- Package ntt_bram_pkg holds:
  - state enum {LOAD, RUN, UNLOAD};
  - constants DEPTH=64, DW=64, AW=10, WORD_SHIFT=2;
  - function word_idx(addr) returning addr>>WORD_SHIFT;
  - function addr_ok(addr).
- One sub-module, ntt_bram_skid: a 2-entry valid/ready output buffer for the unload stream.

Test Plan:
- Load 0..63 with continuous s_valid, then engine reads byte addr 0x0FC -> BRAM_dout_0=63 exactly READ_LAT cycles later; addr 0x000 -> 0.
- In RUN, engine writes 0xDEAD_BEEF to 0x010 with we held 4 cycles, then ntt_done_i rises -> UNLOAD; m_data word 4 = 0xDEADBEEF, other words unchanged, exactly 64 beats, then s_ready=1.
- Unload with m_ready toggled 1,0,0,1 -> no word lost or duplicated; m_data stable while stalled; order 0..63.
- Engine reads addr 0x100 -> dout 0, addr_err=1 and stays 1; write to 0x102 leaves all 64 words intact.
- rst_n pulsed low during RUN at word 30 -> state LOAD, engine_rst=1, m_valid=0, dout=0 within the same asynchronous event; the next load of 64 words proceeds normally.
- ntt_done_i held high across reset release and the full load -> no UNLOAD transition until it drops and rises again.
